// File: rtl/sf_memory.sv
`default_nettype none
// ============================================================================
//  Module   : sf_memory
//  Purpose  : Storage-side responder for the FIFO memory interface. It has a
//             post-reset clear sweep, write-first read-during-write forwarding,
//             a 1- or 2-stage read pipeline, and error pulses for illegal
//             accesses.
//  Revision : 1.0  initial release
// ============================================================================
module sf_memory #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic             fCLK,
  input  logic             fRST,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             busy_o,
  output logic             drop_o,
  output logic             collision_o,
  output logic             addr_err_o
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Depth compared one bit wider so that DEPTH == 2**AW fits.
  localparam logic [AW:0]   DEPTH_EXT   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    clr_ptr;
  logic [AW-1:0]    clr_ptr_next;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             waddr_ok;
  logic             raddr_ok;
  logic             run;
  logic             wr_hit;
  logic             rd_hit;
  logic             same_addr;
  logic [WIDTH-1:0] rd_word;

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;

  // Address qualification and access decode.
  assign waddr_ok  = ({1'b0, waddr_i} < DEPTH_EXT);
  assign raddr_ok  = ({1'b0, raddr_i} < DEPTH_EXT);
  assign run       = (state == ST_RUN);
  assign busy_o    = (state == ST_CLEAR);
  assign wr_hit    = run && we_i && waddr_ok;
  assign rd_hit    = run && re_i;
  // A legal write address equal to the read address implies the read is legal.
  assign same_addr = wr_hit && re_i && (raddr_i == waddr_i);

  // Next-state logic and selection of the single array write port.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    mem_we       = 1'b0;
    mem_waddr    = waddr_i;
    mem_wdata    = wdata_i;
    case (state)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr;
        mem_wdata    = '0;
        clr_ptr_next = clr_ptr + AW'(1);
        if (clr_ptr == LAST_ADDR) begin
          state_next   = ST_RUN;
          clr_ptr_next = '0;
        end
      end
      ST_RUN: begin
        mem_we = wr_hit;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State register and clear pointer.
  always_ff @(posedge fCLK) begin
    if (fRST) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Storage array; contents are never reset directly, only swept.
  always_ff @(posedge fCLK) begin
    if (!fRST && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read word: zero for an illegal address, write data on a same-address hit.
  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if (same_addr) begin
        rd_word = wdata_i;
      end else begin
        rd_word = mem[raddr_i];
      end
    end
  end

  // First read stage; data holds between accepted reads.
  always_ff @(posedge fCLK) begin
    if (fRST) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_hit;
      if (rd_hit) begin
        s1_data <= rd_word;
      end
    end
  end

  // Registered one-cycle error pulses.
  always_ff @(posedge fCLK) begin
    if (fRST) begin
      drop_o      <= 1'b0;
      collision_o <= 1'b0;
      addr_err_o  <= 1'b0;
    end else begin
      drop_o      <= busy_o && (we_i || re_i);
      collision_o <= same_addr;
      addr_err_o  <= run && ((we_i && !waddr_ok) || (re_i && !raddr_ok));
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;

      // Second read stage; data holds between completions.
      always_ff @(posedge fCLK) begin
        if (fRST) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rdata_o  = s2_data;
      assign rvalid_o = s2_valid;
    end else begin : g_lat1
      assign rdata_o  = s1_data;
      assign rvalid_o = s1_valid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/sf_memory.md
Name: sf_memory

Overview:
- Storage-side responder for the FIFO memory interface. It accepts the write port (we/waddr/wdata) and read port (re/raddr) driven by the FIFO controller and returns read data with fixed latency.
- It replaces the behavioural RAM in the FIFO top level.
- It adds a post-reset clear sweep, read-during-write forwarding, a configurable read pipeline, and error pulses for illegal accesses.

Parameters:
- Width, 32, data word width in bits.
- Depth, 16, number of words; any value >= 2, not necessarily a power of two.
- Aw, $clog2(Depth), localparam; address width.
- ReadLatency, 1, cycles from re_i to rdata_o/rvalid_o. Legal values are 1 and 2; 1 matches the FIFO controller's one-cycle valid timing.
- ClearOnReset, 1, when 1, zero all words after reset before accepting accesses.

Ports:
- fCLK  input  1  single clock; all logic on rising edge.
- fRST  input  1  reset, synchronous, active-high.
- we_i  input  1  write enable.
- waddr_i  input  Aw  write address.
- wdata_i  input  Width  write data.
- re_i  input  1  read enable.
- raddr_i  input  Aw  read address.
- rdata_o  output  Width  read data; holds last value between reads.
- rvalid_o  output  1  one-cycle pulse marking new rdata_o.
- busy_o  output  1  clear sweep in progress; accesses dropped.
- drop_o  output  1  pulse: we_i or re_i was presented while busy.
- collision_o  output  1  pulse: we_i and re_i to the same valid address in the same cycle.
- addr_err_o  output  1  pulse: a read or write address was >= Depth.

Behaviour:
- Reset: when fRST is high at a rising edge, the following take their reset values at that edge:
  - rdata_o=0, rvalid_o=0, drop_o=0, collision_o=0, addr_err_o=0.
  - Read pipeline flushed; in-flight reads are lost and produce no rvalid_o.
  - State goes to CLEAR if ClearOnReset=1, else RUN.
  - clr_ptr=0.
  - busy_o=1 if ClearOnReset=1, else 0.
  - Array contents are not reset directly.
- FSM has two states: CLEAR and RUN.
  - CLEAR: write 0 to mem[clr_ptr] each cycle and increment clr_ptr. When clr_ptr==Depth-1, that word is written and the state moves to RUN. This takes exactly Depth cycles, and busy_o is high throughout.
  - RUN: normal service. There is no return to CLEAR except via fRST.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- In CLEAR, we_i and re_i are ignored: no array write, no rvalid_o. drop_o pulses the next cycle if either was high.
- Write (RUN): if we_i and waddr_i<Depth, mem[waddr_i] <= wdata_i at the edge.
- Read (RUN): if re_i, the read is accepted.
  - rdata_o/rvalid_o are updated ReadLatency cycles later. Latency 1: rdata_o is registered directly. Latency 2: one extra register stage for data and valid.
  - Reads can be issued every cycle; throughput is 1 per cycle at either latency.
- Read-during-write to the same address in the same cycle: write-first. The read returns wdata_i, and collision_o pulses the next cycle. The write is still performed.
- Out-of-range address (only possible when Depth is not a power of 2):
  - Write is dropped.
  - Read completes with rvalid_o and rdata_o=0.
  - addr_err_o pulses the next cycle; one pulse even if both ports are illegal.
- rdata_o keeps its value in cycles without read completion; rvalid_o is 0 in those cycles.
- Error pulses are registered, are one cycle wide per offending cycle, and are re-asserted on consecutive offending cycles.
- The FIFO controller never issues same-address read/write or out-of-range accesses. The checks exist for standalone use and must never fire in the FIFO top level.

Test Plan:
- Clear sweep (Depth=16, ClearOnReset=1): pulse fRST for 1 cycle -> busy_o high for exactly 16 cycles then low. Read of addr 0..15 -> all rdata_o=0, rvalid_o one cycle after each re_i.
- Basic write/read (Latency 1): write 0xA5A5_0001 to addr 3, next cycle re_i addr 3 -> rdata_o=0xA5A5_0001, rvalid_o=1 the following cycle. rdata_o holds that value afterwards with rvalid_o=0.
- Back-to-back reads (Latency 2): reads of addr 0,1,2 on three consecutive cycles, holding 0x10,0x11,0x12 -> rvalid_o high for three consecutive cycles starting 2 cycles after the first re_i, with data 0x10,0x11,0x12.
- Collision: we_i addr 5 data 0xDEAD_BEEF with re_i addr 5 in the same cycle; old data 0x1 -> rdata_o=0xDEAD_BEEF, collision_o=1 for one cycle. A later read of addr 5 returns 0xDEAD_BEEF.
- Busy drop and mid-op reset: assert we_i during CLEAR -> drop_o pulse, addr unchanged (0 after sweep). Assert fRST one cycle after re_i at Latency 2 -> no rvalid_o, rdata_o=0, busy_o=1, sweep restarts.
- Out-of-range (Depth=12): write addr 13 -> addr_err_o pulse, no array change. Read addr 14 -> rvalid_o=1, rdata_o=0, addr_err_o pulse.
